flop_mul_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point multiplier, the successor to the team's combinational half-precision multiplier. Generalised in exponent and mantissa width. Adds NaN/Inf/zero special-case handling, overflow and underflow saturation, exception flags and a three-stage pipeline with valid/ready backpressure. Sits between the operand-fetch stage and the FP result mux. Default parameters give binary16.

---
 rtl/flop_mul_pipe.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/flop_mul_pipe.sv
// flop_mul_pipe: three-stage pipelined floating-point multiplier with
// valid/ready backpressure, special-case handling and exception flags.
// Optional feature macro: FLOP_MUL_RNE_EN (round-to-nearest-even); when
// undefined the mantissa is truncated toward zero.
module flop_mul_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   flp_a,
    input  logic [EXP_W+MAN_W:0]   flp_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   prod,
    output logic [3:0]             flags
);

    localparam int unsigned W   = EXP_W + MAN_W + 1;
    localparam int unsigned EW2 = EXP_W + 2;
    localparam int unsigned PW  = 2 * MAN_W + 2;

    localparam logic [EW2-1:0]   BIAS_X   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0]   EXP_ONES = EW2'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0] QNAN_MAN = {1'b1, (MAN_W-1)'(0)};

    // Whole pipeline moves together; it only freezes on a held result.
    logic advance;

    // Operand fields and classes
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    // Stage 1 registers
    logic             v1_q, v1_d;
    logic             sign1_q, sign1_d;
    logic             nan1_q, nan1_d;
    logic             inf1_q, inf1_d;
    logic             zero1_q, zero1_d;
    logic [EW2-1:0]   e1_q, e1_d;
    logic [MAN_W-1:0] ma1_q, ma1_d;
    logic [MAN_W-1:0] mb1_q, mb1_d;

    // Stage 2 registers
    logic             v2_q, v2_d;
    logic             sign2_q, sign2_d;
    logic             nan2_q, nan2_d;
    logic             inf2_q, inf2_d;
    logic             zero2_q, zero2_d;
    logic [EW2-1:0]   e2_q, e2_d;
    logic [PW-1:0]    p2_q, p2_d;

    // Stage 3 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     prod_q, prod_d;
    logic [3:0]       flags_q, flags_d;

    // Stage 3 datapath
    logic             p_msb;
    logic [MAN_W-1:0] man_n;
    logic             guard, sticky, inexact, round_inc, carry;
    logic [MAN_W:0]   man_sum;
    logic [MAN_W-1:0] man_r;
    logic [EW2-1:0]   e_n, e_r;
    logic             ovf, unf;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign prod      = prod_q;
    assign flags     = flags_q;

    // Split operands into fields and classify them
    always_comb begin
        a_sign = flp_a[W-1];
        b_sign = flp_b[W-1];
        a_exp  = flp_a[W-2 -: EXP_W];
        b_exp  = flp_b[W-2 -: EXP_W];
        a_man  = flp_a[MAN_W-1:0];
        b_man  = flp_b[MAN_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (&a_exp) & ~(|a_man);
        b_inf  = (&b_exp) & ~(|b_man);
        a_nan  = (&a_exp) & (|a_man);
        b_nan  = (&b_exp) & (|b_man);
    end

    // S1: sign, special class and biased exponent sum
    always_comb begin
        v1_d    = v1_q;
        sign1_d = sign1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        zero1_d = zero1_q;
        e1_d    = e1_q;
        ma1_d   = ma1_q;
        mb1_d   = mb1_q;
        if (advance) begin
            v1_d    = in_valid;
            sign1_d = a_sign ^ b_sign;
            nan1_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf1_d  = a_inf | b_inf;
            zero1_d = a_zero | b_zero;
            e1_d    = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X;
            ma1_d   = a_man;
            mb1_d   = b_man;
        end
    end

    // S2: mantissa product including hidden bits
    always_comb begin
        v2_d    = v2_q;
        sign2_d = sign2_q;
        nan2_d  = nan2_q;
        inf2_d  = inf2_q;
        zero2_d = zero2_q;
        e2_d    = e2_q;
        p2_d    = p2_q;
        if (advance) begin
            v2_d    = v1_q;
            sign2_d = sign1_q;
            nan2_d  = nan1_q;
            inf2_d  = inf1_q;
            zero2_d = zero1_q;
            e2_d    = e1_q;
            p2_d    = PW'({1'b1, ma1_q}) * PW'({1'b1, mb1_q});
        end
    end

    // S3: normalise, round, range check and special selection
    always_comb begin
        p_msb  = p2_q[PW-1];
        man_n  = p_msb ? p2_q[PW-2 -: MAN_W] : p2_q[PW-3 -: MAN_W];
        guard  = p_msb ? p2_q[PW-2-MAN_W] : p2_q[PW-3-MAN_W];
        sticky = p_msb ? (|p2_q[PW-3-MAN_W:0]) : (|p2_q[PW-4-MAN_W:0]);
        inexact = guard | sticky;
        e_n    = e2_q + EW2'(p_msb);
`ifdef FLOP_MUL_RNE_EN
        round_inc = guard & (sticky | man_n[0]);
`else
        round_inc = 1'b0;
`endif
        man_sum = {1'b0, man_n} + (MAN_W+1)'(round_inc);
        carry   = man_sum[MAN_W];
        man_r   = carry ? '0 : man_sum[MAN_W-1:0];
        e_r     = e_n + EW2'(carry);
        ovf     = ($signed(e_r) >= $signed(EXP_ONES));
        unf     = e_r[EW2-1] | (e_r == '0);

        out_valid_d = out_valid_q;
        prod_d      = prod_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                if (nan2_q) begin
                    prod_d  = {1'b0, {EXP_W{1'b1}}, QNAN_MAN};
                    flags_d = 4'b1000;
                end else if (inf2_q) begin
                    prod_d  = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0000;
                end else if (zero2_q) begin
                    prod_d  = {sign2_q, {(W-1){1'b0}}};
                    flags_d = 4'b0000;
                end else if (ovf) begin
                    prod_d  = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (unf) begin
                    prod_d  = {sign2_q, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    prod_d  = {sign2_q, e_r[EXP_W-1:0], man_r};
                    flags_d = {3'b000, inexact};
                end
            end
        end
    end

    // Pipeline state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            nan1_q      <= 1'b0;
            inf1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            e1_q        <= '0;
            ma1_q       <= '0;
            mb1_q       <= '0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            nan2_q      <= 1'b0;
            inf2_q      <= 1'b0;
            zero2_q     <= 1'b0;
            e2_q        <= '0;
            p2_q        <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            flags_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            sign1_q     <= sign1_d;
            nan1_q      <= nan1_d;
            inf1_q      <= inf1_d;
            zero1_q     <= zero1_d;
            e1_q        <= e1_d;
            ma1_q       <= ma1_d;
            mb1_q       <= mb1_d;
            v2_q        <= v2_d;
            sign2_q     <= sign2_d;
            nan2_q      <= nan2_d;
            inf2_q      <= inf2_d;
            zero2_q     <= zero2_d;
            e2_q        <= e2_d;
            p2_q        <= p2_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
            flags_q     <= flags_d;
        end
    end

endmodule
